// File: rtl/dm_responder.sv
// Data-memory responder: one load/store in flight, completed after LATENCY wait cycles,
// with byte-lane stores, sign/zero-extended loads and fault flagging.
module dm_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  width,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: req is sampled on a rising edge only in IDLE or RESP (busy=0); a req seen
  // while busy=1 is discarded. Every accepted request yields exactly one ack pulse, with
  // rdata/err valid only in that cycle. There is no backpressure on the response.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LAT   = 4'(LATENCY);
  localparam int         WORDS = 1 << ADDR_W;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, commit;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  width_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        width_q <= width;
      end
    end
  end

  // A commit out of WAIT uses the captured request; a zero-latency commit uses the live inputs.
  logic        op_we;
  logic [31:0] op_addr, op_wdata;
  logic [2:0]  op_width;
  always_comb begin
    if (state_q == WAIT) begin
      op_we    = we_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_width = width_q;
    end else begin
      op_we    = we;
      op_addr  = addr;
      op_wdata = wdata;
      op_width = width;
    end
  end

  logic [1:0]        lane;
  logic [ADDR_W-1:0] idx;
  logic              is_word, is_half, is_byte, fault;
  logic [31:0]       word, load_val, wlane;
  logic [15:0]       half_v;
  logic [7:0]        byte_v;
  logic [3:0]        be;

  always_comb begin
    lane     = op_addr[1:0];
    idx      = op_addr[ADDR_W+1:2];
    is_word  = (op_width == 3'd0);
    is_half  = (op_width == 3'd1) || (op_width == 3'd2);
    is_byte  = (op_width == 3'd3) || (op_width == 3'd4);
    fault    = (op_width > 3'd4) || (is_word && (lane != 2'b00)) ||
               (is_half && lane[0]) || ((op_addr >> (ADDR_W + 2)) != 32'd0);
    word     = mem_q[idx];
    half_v   = lane[1] ? word[31:16] : word[15:0];
    byte_v   = word[{lane, 3'b000} +: 8];
    case (op_width)
      3'd0:    load_val = word;
      3'd1:    load_val = {{16{half_v[15]}}, half_v};
      3'd2:    load_val = {16'h0000, half_v};
      3'd3:    load_val = {{24{byte_v[7]}}, byte_v};
      3'd4:    load_val = {24'h000000, byte_v};
      default: load_val = 32'd0;
    endcase
    be    = 4'b0000;
    wlane = op_wdata;
    if (is_word) begin
      be = 4'b1111;
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wlane = {2{op_wdata[15:0]}};
    end else if (is_byte) begin
      be    = 4'b0001 << lane;
      wlane = {4{op_wdata[7:0]}};
    end
    rdata_d = (commit && !fault && !op_we) ? load_val : 32'd0;
    err_d   = commit && fault;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (commit && op_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign busy      = (state_q == WAIT);
  assign ack       = (state_q == RESP);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/dm_responder.md
# dm_responder

Responder side of the M-stage data-memory interface. Accepts one load/store request at a time from the pipeline's memory stage and completes it after a configurable number of wait states. Handles byte/half/word stores with byte-lane placement and loads with sign/zero extension. Flags misaligned, illegal-width and out-of-range accesses instead of performing them. Sits between the Memory stage and the storage array, in place of a zero-latency DM.

## Interface

Parameters:
- ADDR_W, 12: word-address bits; the array is 2^ADDR_W 32-bit words.
- LATENCY, 2: wait cycles between accept and response; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and the array.
- req  in  1  request strobe; sampled only when the block can accept.
- we  in  1  1 = store, 0 = load; qualified by req.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte/half is used for narrow stores.
- width  in  3  0 = word, 1 = half signed, 2 = half unsigned, 3 = byte signed, 4 = byte unsigned; 5..7 are illegal.
- busy  out  1  high while a request is in its wait cycles; req is ignored while high.
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  load result; valid only while ack=1, otherwise 0.
- err  out  1  access faulted; valid only while ack=1, otherwise 0.

## Operation

States: IDLE, WAIT, RESP.

Transitions:
- IDLE with req=1: go to WAIT if LATENCY>0, else go to RESP.
- WAIT: go to RESP when the wait counter expires.
- RESP with req=1: accept the new request and go to WAIT (or RESP if LATENCY=0).
- RESP with req=0: go to IDLE.

Accept:
- Accepting a request captures we, addr, wdata and width into internal registers.
- The wait counter loads LATENCY. It decrements once per WAIT cycle, and WAIT exits when it reaches 1.
- Later changes on the inputs do not affect an accepted request.

Fault check, at accept:
- err=1 if width is 5..7.
- err=1 if a word access has addr[1:0]≠0.
- err=1 if a half access has addr[0]≠0.
- err=1 if addr[31:ADDR_W+2]≠0.
- A faulted request never writes the array, and returns rdata=0 with err=1.

Store:
- Word index is addr[ADDR_W+1:2].
- Word store: all four bytes from wdata.
- Half store: wdata[15:0] goes to bytes {addr[1],1'b1}:{addr[1],1'b0}.
- Byte store: wdata[7:0] goes to byte addr[1:0].
- Other bytes of the word are unchanged.
- The width extension setting (signed/unsigned) is irrelevant for stores.

Load:
- Read the addressed word and select the half or byte by addr[1:0].
- Extend to 32 bits: sign-extend for widths 1 and 3, zero-extend for widths 2 and 4.
- A word load returns the word unchanged.
- A store returns rdata=0.

Request and reset rules:
- A req while busy=1 is dropped: not queued, and no ack is ever produced for it.
- Reset while in any state returns to IDLE and zeroes the array.
- A store that had not yet committed when reset hit is lost.

## Timing

- Reset values: busy=0, ack=0, rdata=0, err=0, state IDLE, counter 0, array all zero.
- A request sampled at the edge ending cycle T is answered by ack=1 during cycle T+1+LATENCY, for exactly one cycle.
- busy=1 during cycles T+1..T+LATENCY. busy=0 during the ack cycle.
- A store commits on the edge that enters RESP, so any load accepted in or after the ack cycle sees the new data.
- A load reads the array on the same edge that enters RESP. rdata and err are registered and appear with ack.
- A req in the ack cycle is accepted. Back-to-back throughput is one access per LATENCY+1 cycles.
- With LATENCY=0, busy is never asserted and one access completes per cycle.
- Reset asserted mid-WAIT forces busy, ack and err to 0 immediately (asynchronous). No ack follows the reset.

## Test plan

All scenarios use LATENCY=2 unless stated otherwise.

- **Word store/load:** word store of 0xDEADBEEF to 0x10, accepted at T, gives ack at T+3 with err=0. A word load of 0x10 then returns rdata=0xDEADBEEF.
- **Byte lanes and extension:** after a byte store of wdata=0x00000080 to 0x13:
  - word load of 0x10 returns 0x80ADBEEF;
  - signed byte load of 0x13 returns 0xFFFFFF80;
  - unsigned byte load of 0x13 returns 0x00000080;
  - signed half load of 0x12 returns 0xFFFF80AD.
- **Faults:**
  - signed half load at 0x11 gives ack with err=1 and rdata=0;
  - word store of 0x12345678 to 0x12 gives err=1, and a later word load of 0x10 still returns 0x80ADBEEF;
  - width=6 gives err=1;
  - addr=0x00010000 with ADDR_W=12 gives err=1.
- **Handshake:**
  - req held high continuously gives acks at T+3, T+6, T+9;
  - a single req pulsed during busy produces no ack.
- **Reset mid-operation:** word store of 0x11111111 to 0x20 with reset asserted in the first WAIT cycle gives no ack. After reset, a word load of 0x20 returns 0x00000000.
- **LATENCY=0 instance:** req high for 4 cycles with alternating store/load to 0x04 gives an ack in every cycle after the first. Each load returns the data stored in the preceding cycle, and busy stays 0 throughout.
